// File: rtl/core_ldst_multiple_seq.sv
// -----------------------------------------------------------------------------
// core_ldst_multiple_seq
//
// Purpose:
//   Load/store-multiple sequencer for the memory stage. It latches a decoded
//   register list, base value and addressing mode on `start`. It then issues
//   one word transfer per selected register through a valid/ready handshake.
//   The lowest register number goes to the lowest address. The sequence ends
//   with a one-cycle `done` pulse that carries the base-register writeback
//   value.
//
// Optional feature macro:
//   CORE_LDST_MULT_ABORT_EN - when defined, adds the `abort` input. That input
//                             cancels a running sequence. The sequence still
//                             ends with `done`, but `wb_valid` is 0.
//
// Ports:
//   clk          in   1   core clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   launch a sequence (sampled in IDLE only)
//   regs         in  16   register list, bit i selects Ri
//   base         in  32   current Rn value
//   increment    in   1   1 = IA/IB, 0 = DA/DB
//   pre_indexed  in   1   1 = IB/DB, 0 = IA/DA
//   writeback    in   1   request an Rn update at completion
//   abort        in   1   cancel the sequence (CORE_LDST_MULT_ABORT_EN only)
//   busy         out  1   high in every state except IDLE
//   xfer_valid   out  1   transfer request valid
//   xfer_ready   in   1   transfer accepted by the memory side
//   xfer_reg     out  4   register index of the current transfer
//   xfer_addr    out 32   word address of the current transfer
//   xfer_last    out  1   current transfer is the final one
//   done         out  1   one-cycle completion pulse
//   wb_valid     out  1   with done: write wb_value to Rn
//   wb_value     out 32   new Rn value
//
// All outputs come straight from flops.
// DONE occupies two cycles:
//   - a quiet cycle first;
//   - then the cycle with the `done` pulse.
// As a result, `done` arrives n+2 cycles after `start`, and `busy` stays high
// through the pulse. A new `start` is therefore taken in the cycle after
// `done`.
// -----------------------------------------------------------------------------
module core_ldst_multiple_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] regs,
  input  logic [31:0] base,
  input  logic        increment,
  input  logic        pre_indexed,
  input  logic        writeback,
`ifdef CORE_LDST_MULT_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic [3:0]  xfer_reg,
  output logic [31:0] xfer_addr,
  output logic        xfer_last,
  output logic        done,
  output logic        wb_valid,
  output logic [31:0] wb_value
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of set bits in a 16-bit register list (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit. Returns 0 for an empty list.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[3:0];
      end
    end
    return idx;
  endfunction

  state_t      state_q;
  logic [15:0] rem_q;       // registers still to be transferred
  logic [4:0]  cnt_q;       // popcount of rem_q
  logic        wb_en_q;     // latched writeback request
  logic        pulse_q;     // second DONE cycle (done pulse) in progress
  logic        busy_q;
  logic        xfer_valid_q;
  logic [3:0]  xfer_reg_q;
  logic [31:0] xfer_addr_q;
  logic        xfer_last_q;
  logic        done_q;
  logic        wb_valid_q;
  logic [31:0] wb_value_q;

  logic [4:0]  n_s;
  logic [31:0] four_n_s;
  logic [31:0] base_al_s;
  logic [31:0] start_addr_s;
  logic [31:0] wb_calc_s;
  logic [15:0] rem_d;
  logic [4:0]  cnt_d;
  logic        abort_s;

`ifdef CORE_LDST_MULT_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Compute the start address and the writeback value from live inputs.
  // Also compute the list and count left after a handshake.
  always_comb begin
    n_s       = popcount16(regs);
    four_n_s  = {25'd0, n_s, 2'b00};
    base_al_s = {base[31:2], 2'b00};
    case ({increment, pre_indexed})
      2'b10:   start_addr_s = base_al_s;                        // IA
      2'b11:   start_addr_s = base_al_s + 32'd4;                // IB
      2'b00:   start_addr_s = base_al_s - four_n_s + 32'd4;     // DA
      2'b01:   start_addr_s = base_al_s - four_n_s;             // DB
      default: start_addr_s = base_al_s;
    endcase
    // The writeback uses the unmasked base. For n=0 this gives base itself.
    if (increment) begin
      wb_calc_s = base + four_n_s;
    end else begin
      wb_calc_s = base - four_n_s;
    end
    rem_d = rem_q & ~(16'd1 << xfer_reg_q);
    cnt_d = cnt_q - 5'd1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= 16'd0;
      cnt_q        <= 5'd0;
      wb_en_q      <= 1'b0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      xfer_valid_q <= 1'b0;
      xfer_reg_q   <= 4'd0;
      xfer_addr_q  <= 32'd0;
      xfer_last_q  <= 1'b0;
      done_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_value_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q     <= 1'b0;
          wb_valid_q <= 1'b0;
          pulse_q    <= 1'b0;
          if (start) begin
            rem_q      <= regs;
            cnt_q      <= n_s;
            wb_en_q    <= writeback;
            wb_value_q <= wb_calc_s;
            busy_q     <= 1'b1;
            if (n_s != 5'd0) begin
              state_q      <= ST_ISSUE;
              xfer_valid_q <= 1'b1;
              xfer_reg_q   <= lowest_set(regs);
              xfer_addr_q  <= start_addr_s;
              xfer_last_q  <= (n_s == 5'd1);
            end else begin
              state_q <= ST_DONE;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Abort wins over a handshake in the same cycle.
          if (abort_s) begin
            state_q      <= ST_DONE;
            xfer_valid_q <= 1'b0;
            xfer_last_q  <= 1'b0;
            wb_en_q      <= 1'b0;
          end else if (xfer_ready) begin
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            if (xfer_last_q) begin
              state_q      <= ST_DONE;
              xfer_valid_q <= 1'b0;
              xfer_last_q  <= 1'b0;
            end else begin
              xfer_reg_q  <= lowest_set(rem_d);
              xfer_addr_q <= xfer_addr_q + 32'd4;
              xfer_last_q <= (cnt_d == 5'd1);
            end
          end else begin
            // Stalled: hold the request.
            xfer_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!pulse_q) begin
            pulse_q    <= 1'b1;
            done_q     <= 1'b1;
            wb_valid_q <= wb_en_q;
          end else begin
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          xfer_valid_q <= 1'b0;
          xfer_last_q  <= 1'b0;
          done_q       <= 1'b0;
          wb_valid_q   <= 1'b0;
          pulse_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign xfer_valid = xfer_valid_q;
  assign xfer_reg   = xfer_reg_q;
  assign xfer_addr  = xfer_addr_q;
  assign xfer_last  = xfer_last_q;
  assign done       = done_q;
  assign wb_valid   = wb_valid_q;
  assign wb_value   = wb_value_q;

endmodule

// File: tb/tb_core_ldst_multiple_seq.sv
// -----------------------------------------------------------------------------
// Testbench for core_ldst_multiple_seq.
//
// Structure:
//   - A table of directed vectors, each with a hand-computed first address
//     and writeback value, run with xfer_ready held high.
//   - Hand-written sequences for:
//       * stall behaviour;
//       * start pulses while busy;
//       * reset in mid-sequence;
//       * abort, when CORE_LDST_MULT_ABORT_EN is defined.
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge as well.
// -----------------------------------------------------------------------------
module tb_core_ldst_multiple_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] regs;
  logic [31:0] base;
  logic        increment;
  logic        pre_indexed;
  logic        writeback;
`ifdef CORE_LDST_MULT_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [3:0]  xfer_reg;
  logic [31:0] xfer_addr;
  logic        xfer_last;
  logic        done;
  logic        wb_valid;
  logic [31:0] wb_value;

  int tests_run;
  int tests_failed;
  int hs_count;

  core_ldst_multiple_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .regs        (regs),
    .base        (base),
    .increment   (increment),
    .pre_indexed (pre_indexed),
    .writeback   (writeback),
`ifdef CORE_LDST_MULT_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .xfer_valid  (xfer_valid),
    .xfer_ready  (xfer_ready),
    .xfer_reg    (xfer_reg),
    .xfer_addr   (xfer_addr),
    .xfer_last   (xfer_last),
    .done        (done),
    .wb_valid    (wb_valid),
    .wb_value    (wb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted transfers.
  always @(posedge clk) begin
    if (rst_n && xfer_valid && xfer_ready) begin
      hs_count <= hs_count + 1;
    end
  end

  typedef struct {
    logic [15:0] regs;
    logic [31:0] base;
    logic        inc;
    logic        pre;
    logic        wbreq;
    int          n;
    logic [31:0] first_addr;
    logic [31:0] wb_val;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int low_bit(input logic [15:0] v);
    int i;
    i = 0;
    while (i < 15 && !v[i]) begin
      i++;
    end
    return i;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".busy"},       {31'd0, busy},       32'd0);
    chk({tag, ".xfer_valid"}, {31'd0, xfer_valid}, 32'd0);
    chk({tag, ".xfer_last"},  {31'd0, xfer_last},  32'd0);
    chk({tag, ".done"},       {31'd0, done},       32'd0);
    chk({tag, ".wb_valid"},   {31'd0, wb_valid},   32'd0);
    chk({tag, ".xfer_reg"},   {28'd0, xfer_reg},   32'd0);
    chk({tag, ".xfer_addr"},  xfer_addr,           32'd0);
    chk({tag, ".wb_value"},   wb_value,            32'd0);
  endtask

  // Apply one vector with ready held high and check every cycle to done.
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] rem;
    int          er;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    regs = v.regs; base = v.base; increment = v.inc; pre_indexed = v.pre;
    writeback = v.wbreq; xfer_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    // Scramble the inputs to show that the values were latched.
    start = 1'b0; regs = 16'hFFFF; base = 32'hDEAD_BEE0; increment = ~v.inc;
    rem = v.regs;
    for (int k = 0; k < v.n; k++) begin
      er = low_bit(rem);
      chk({tag, ".valid"}, {31'd0, xfer_valid}, 32'd1);
      chk({tag, ".reg"},   {28'd0, xfer_reg},   er);
      chk({tag, ".addr"},  xfer_addr,           v.first_addr + 32'(4 * k));
      chk({tag, ".last"},  {31'd0, xfer_last},  (k == v.n - 1) ? 32'd1 : 32'd0);
      chk({tag, ".done_early"}, {31'd0, done},  32'd0);
      rem[er] = 1'b0;
      @(negedge clk);
    end
    chk({tag, ".gap_valid"}, {31'd0, xfer_valid}, 32'd0);
    chk({tag, ".gap_done"},  {31'd0, done},       32'd0);
    chk({tag, ".gap_busy"},  {31'd0, busy},       32'd1);
    @(negedge clk);
    chk({tag, ".done"},      {31'd0, done},       32'd1);
    chk({tag, ".wb_valid"},  {31'd0, wb_valid},   {31'd0, v.wbreq});
    chk({tag, ".wb_value"},  wb_value,            v.wb_val);
    chk({tag, ".done_busy"}, {31'd0, busy},       32'd1);
    @(negedge clk);
    chk({tag, ".after_done"}, {31'd0, done},      32'd0);
    chk({tag, ".after_busy"}, {31'd0, busy},      32'd0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; hs_count = 0;
    rst_n = 1'b0; start = 1'b0; regs = 16'd0; base = 32'd0;
    increment = 1'b0; pre_indexed = 1'b0; writeback = 1'b0; xfer_ready = 1'b0;
`ifdef CORE_LDST_MULT_ABORT_EN
    abort = 1'b0;
`endif

    //           regs      base           inc   pre   wb    n   first_addr     wb_val
    vecs[0] = '{16'h000B, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 3,  32'h0000_1000, 32'h0000_100C}; // IA
    vecs[1] = '{16'h8001, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 2,  32'h0000_1FF8, 32'h0000_1FF8}; // DB
    vecs[2] = '{16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 2,  32'h0000_0000, 32'h0000_0004}; // IB wrap
    vecs[3] = '{16'h0000, 32'h0000_3000, 1'b0, 1'b0, 1'b1, 0,  32'h0000_0000, 32'h0000_3000}; // DA empty
    vecs[4] = '{16'h0110, 32'h0000_4003, 1'b0, 1'b0, 1'b1, 2,  32'h0000_3FFC, 32'h0000_3FFB}; // DA unaligned
    vecs[5] = '{16'hFFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16, 32'h0000_0000, 32'h0000_0040}; // IA full
    vecs[6] = '{16'h8000, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1,  32'h0000_0104, 32'h0000_0104}; // IB single

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Stall on the second transfer. Start pulses while busy must be ignored.
    @(negedge clk);
    regs = 16'h0007; base = 32'h0000_5000; increment = 1'b1; pre_indexed = 1'b0;
    writeback = 1'b1; xfer_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stall.r0_reg",  {28'd0, xfer_reg}, 32'd0);
    chk("stall.r0_addr", xfer_addr,         32'h0000_5000);
    @(negedge clk);
    xfer_ready = 1'b0; start = 1'b1; regs = 16'h00F0; base = 32'h0000_9000;
    for (int c = 0; c < 4; c++) begin
      chk("stall.valid", {31'd0, xfer_valid}, 32'd1);
      chk("stall.reg",   {28'd0, xfer_reg},   32'd1);
      chk("stall.addr",  xfer_addr,           32'h0000_5004);
      chk("stall.last",  {31'd0, xfer_last},  32'd0);
      if (c < 3) begin
        @(negedge clk);
      end
    end
    xfer_ready = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("stall.r2_reg",  {28'd0, xfer_reg},   32'd2);
    chk("stall.r2_addr", xfer_addr,           32'h0000_5008);
    chk("stall.r2_last", {31'd0, xfer_last},  32'd1);
    @(negedge clk);
    chk("stall.gap_valid", {31'd0, xfer_valid}, 32'd0);
    @(negedge clk);
    chk("stall.done",     {31'd0, done},     32'd1);
    chk("stall.wb_value", wb_value,          32'h0000_500C);
    @(negedge clk);
    @(negedge clk);
    chk("stall.no_restart", {31'd0, busy},   32'd0);

    // Reset in mid-sequence.
    regs = 16'hFFFF; base = 32'h0000_8000; increment = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || xfer_valid || busy) begin
        chk("midrst.quiet", {29'd0, done, xfer_valid, busy}, 32'd0);
      end
    end
    chk("midrst.final_busy", {31'd0, busy}, 32'd0);

`ifdef CORE_LDST_MULT_ABORT_EN
    // Abort in the handshake cycle of the 4th transfer.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort.idle_ignored", {31'd0, busy}, 32'd0);
    abort = 1'b0; hs_count = 0;
    regs = 16'hFFFF; base = 32'h0000_0000; increment = 1'b1; pre_indexed = 1'b0;
    writeback = 1'b1; xfer_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort.r3_reg", {28'd0, xfer_reg}, 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.valid_off", {31'd0, xfer_valid}, 32'd0);
    chk("abort.busy",      {31'd0, busy},       32'd1);
    @(negedge clk);
    chk("abort.done",      {31'd0, done},       32'd1);
    chk("abort.wb_valid",  {31'd0, wb_valid},   32'd0);
    chk("abort.xfers",     hs_count,            32'd4);
    @(negedge clk);
    chk("abort.idle",      {31'd0, busy},       32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
